// File: rtl/arbiter_out_fifo.sv
// First-word-fall-through FIFO behind the arbiter root; a pushed beat is visible one cycle later.
// Backpressure: ready_out depends only on registered occupancy, never combinationally on ready_in.
module arbiter_out_fifo #(
    parameter int DW       = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [DW-1:0]            data_in,
    output logic                     ready_out,
    output logic                     valid_out,
    output logic [DW-1:0]            data_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LEVEL);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic          push;
    logic          pop;

    // Full/empty come from the occupancy counter; equal pointers are ambiguous.
    assign ready_out   = !rst && (count_q != FULL_CNT);
    assign valid_out   = !rst && (count_q != '0);
    assign data_out    = valid_out ? mem[rd_ptr] : '0;
    assign count       = rst ? '0 : count_q;
    assign almost_full = !rst && (count_q >= AF_CNT);

    assign push = valid_in && ready_out;
    assign pop  = valid_out && ready_in;

    // Storage is intentionally left unreset; valid_out masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst) count_q <= FULL_CNT);
    assert property (@(posedge clk) disable iff (rst) (count_q == FULL_CNT) |-> !ready_out);
    assert property (@(posedge clk) disable iff (rst) (count_q == '0) |-> !valid_out);
    assert property (@(posedge clk) disable iff (rst)
                     (valid_out && !ready_in) |=> (rst || data_out == $past(data_out)));

endmodule

// File: tb/tb_arbiter_out_fifo.sv
// Bench for arbiter_out_fifo: directed vector table, reset-mid-stream sequence, randomized queue model.
module tb_arbiter_out_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = DEPTH - 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ready_out;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          ready_in;
    logic [4:0]    count;
    logic          almost_full;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arbiter_out_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .ready_out   (ready_out),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .ready_in    (ready_in),
        .count       (count),
        .almost_full (almost_full)
    );

    typedef struct {
        logic       rst;
        logic       vin;
        logic [7:0] din;
        logic       rdy;
        logic       er;
        logic       ev;
        logic [7:0] ed;
        logic [4:0] ec;
        logic       eaf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic vi, input logic [7:0] di, input logic rd,
                                input logic er, input logic ev, input logic [7:0] ed,
                                input int ec, input logic eaf);
        vec_t v;
        v.rst = r;  v.vin = vi; v.din = di; v.rdy = rd;
        v.er  = er; v.ev  = ev; v.ed  = ed; v.ec  = 5'(ec); v.eaf = eaf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic vi, input logic [7:0] di, input logic rd);
        @(negedge clk);
        rst = r; valid_in = vi; data_in = di; ready_in = rd;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic er, input logic ev, input logic [7:0] ed,
                              input logic [4:0] ec, input logic eaf);
        chk({tag, ".ready_out"},   32'(ready_out),   32'(er));
        chk({tag, ".valid_out"},   32'(valid_out),   32'(ev));
        chk({tag, ".data_out"},    32'(data_out),    32'(ed));
        chk({tag, ".count"},       32'(count),       32'(ec));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(eaf));
    endtask

    logic [7:0] q[$];

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held, then idle release
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));
        // Fill 0x01..0x10 with sink stalled
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 1, 8'(i + 1), 0, 1, i > 0, (i > 0) ? 8'h01 : 8'h00, i, i >= AFL));
        vecs.push_back(mk(0, 1, 8'hAA, 0, 0, 1, 8'h01, 16, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h01, 16, 1));
        // Drain
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 0, 8'h00, 1, i > 0, 1, 8'(i + 1), 16 - i, (16 - i) >= AFL));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));
        // Full with simultaneous pop: push refused, accepted next cycle
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 1, 8'(8'h20 + i), 0, 1, i > 0, (i > 0) ? 8'h20 : 8'h00, i, i >= AFL));
        vecs.push_back(mk(0, 1, 8'h55, 1, 0, 1, 8'h20, 16, 1));
        vecs.push_back(mk(0, 1, 8'h55, 0, 1, 1, 8'h21, 15, 1));
        for (int i = 0; i < 16; i++)
            vecs.push_back(mk(0, 0, 8'h00, 1, i > 0, 1, (i < 15) ? 8'(8'h21 + i) : 8'h55,
                              16 - i, (16 - i) >= AFL));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));
        // Streaming 40 beats through a wrapping pointer pair
        for (int k = 0; k < 40; k++)
            vecs.push_back(mk(0, 1, 8'(k), 1, 1, k > 0, (k > 0) ? 8'(k - 1) : 8'h00, (k > 0) ? 1 : 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'd39, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].vin, vecs[i].din, vecs[i].rdy);
            check_outs($sformatf("vec%0d", i), vecs[i].er, vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].eaf);
        end

        // Reset mid-stream with seven beats queued
        for (int i = 0; i < 7; i++) drive(0, 1, 8'(8'h40 + i), 0);
        drive(0, 0, 8'h00, 0);
        check_outs("pre_rst", 1, 1, 8'h40, 7, 0);
        drive(1, 0, 8'h00, 1);
        check_outs("in_rst", 0, 0, 8'h00, 0, 0);
        drive(0, 1, 8'h33, 0);
        check_outs("post_rst_push", 1, 0, 8'h00, 0, 0);
        drive(0, 0, 8'h00, 1);
        check_outs("post_rst_head", 1, 1, 8'h33, 1, 0);
        drive(0, 0, 8'h00, 0);
        check_outs("post_rst_empty", 1, 0, 8'h00, 0, 0);

        // Randomized traffic against a queue model
        q.delete();
        for (int e = 0; e < 30; e++) begin
            int pv;
            int pr;
            pv = $urandom_range(10, 100);
            pr = $urandom_range(10, 100);
            for (int c = 0; c < 100; c++) begin
                logic       r;
                logic       vi;
                logic       rd;
                logic [7:0] di;
                logic       m_rdy;
                logic       m_vld;
                logic [7:0] m_dat;
                logic [4:0] m_cnt;
                logic       m_af;
                r  = ($urandom_range(0, 199) == 0);
                vi = ($urandom_range(1, 100) <= pv);
                rd = ($urandom_range(1, 100) <= pr);
                di = 8'($urandom);
                drive(r, vi, di, rd);
                m_rdy = !r && (q.size() != DEPTH);
                m_vld = !r && (q.size() != 0);
                m_dat = m_vld ? q[0] : 8'h00;
                m_cnt = r ? 5'd0 : 5'(q.size());
                m_af  = !r && (q.size() >= AFL);
                check_outs("rnd", m_rdy, m_vld, m_dat, m_cnt, m_af);
                if (r) begin
                    q.delete();
                end else begin
                    if (m_vld && rd) void'(q.pop_front());
                    if (vi && m_rdy) q.push_back(di);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arbiter_out_fifo.md
Name: arbiter_out_fifo

Overview:
- Synchronous first-word-fall-through FIFO that sits directly downstream of arbiter_generic.
- Absorbs the single DW-bit valid/ready stream from the tree root and decouples it from the sink's backpressure.
- The arbiter's root ready therefore depends only on FIFO occupancy.
- Exports occupancy and almost-full status for flow-control monitoring.

Parameters:
- DW, 8, data width; must equal arbiter_generic DW.
- DEPTH, 16, number of entries; power of 2, >= 2.
- AW, log2(DEPTH), pointer width; derived localparam, not user-set.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  upstream beat valid (from arbiter valid_out).
- data_in  input  DW  upstream beat data (from arbiter data_out).
- ready_out  output  1  FIFO can accept (to arbiter ready_in).
- valid_out  output  1  head entry available to sink.
- data_out  output  DW  head entry data.
- ready_in  input  1  sink accepts head entry.
- count  output  AW+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AF_LEVEL.

Behaviour:
- Reset: rst sampled on clk rising edge only.
  - While rst=1 and on the first cycle after it: wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: valid_out=0, data_out=0, almost_full=0.
  - ready_out is forced 0 whenever rst=1, and is 1 in the first cycle after rst deasserts.
  - Storage array is not reset.
- Push when valid_in && ready_out: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
- Pop when valid_out && ready_in: rd_ptr increments modulo DEPTH.
- count update per edge: +1 on push only, -1 on pop only, unchanged on both or neither.
- ready_out = !rst && (count != DEPTH). It is combinational from registered state only and never depends on ready_in.
  - When full, a same-cycle pop does NOT enable a push.
  - No combinational ready path from sink to arbiter.
- valid_out = (count != 0). data_out = mem[rd_ptr] when valid_out, else 0.
- Latency: a beat pushed at edge N is visible at valid_out/data_out in the cycle after edge N. There is no empty-FIFO bypass.
- Ordering: strict FIFO.
- The upstream AXI-style rule holds: once valid_out=1, data_out stays stable until popped. The FIFO does not require the same rule of valid_in.
- Empty + pop attempt: impossible, since valid_out=0.
- Full + push attempt: impossible, since ready_out=0. No overflow or underflow state exists.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no bubble. Full vs empty is distinguished by count, not by pointer equality.
- Simultaneous push and pop at count=1: count stays 1, head advances to the new beat; ordering is preserved.
- Reset mid-operation: all queued beats are discarded. valid_out falls to 0 in the cycle after the reset edge, and pre-reset contents are never presented.
- almost_full is combinational from count and is 0 during reset.
- Assertions for verification:
  - count never exceeds DEPTH.
  - ready_out=0 whenever count=DEPTH.
  - valid_out=0 whenever count=0.
  - data_out stable while valid_out && !ready_in.

Test Plan:
- Reset then idle (DEPTH=16): hold rst 3 cycles, then release -> during rst ready_out=0, valid_out=0, count=0; first cycle after, ready_out=1, count=0, almost_full=0.
- Fill with ready_in=0: push 0x01..0x10 on 16 consecutive cycles -> count steps 1..16; almost_full rises when count=14; ready_out=0 at count=16. A 17th valid_in beat 0xAA is not accepted, and count stays 16.
- Drain: from full, hold ready_in=1 -> data_out sequence 0x01..0x10 one per cycle; valid_out=0 and count=0 after the 16th pop; ready_out returns to 1 after the first pop edge.
- Streaming wrap-around: valid_in=ready_in=1 continuously for 40 beats, data 0..39 -> after the one-cycle fill latency count holds at 1, the output sequence is 0..39 in order, and pointers wrap twice with no dropped or duplicated beat.
- Full with simultaneous pop: at count=16, drive valid_in=1 with 0x55 and ready_in=1 -> pop occurs, push is refused (ready_out=0 that cycle), count=15; next cycle 0x55 is accepted and count=16.
- Reset mid-stream: with count=7, assert rst for 1 cycle -> next cycle count=0 and valid_out=0; a subsequent push of 0x33 is the first data_out seen, one cycle later.
